// File: rtl/data_xf_pkg.sv
// Shared definitions for the 4x4 byte-matrix transform sequencer.
// Element/row/matrix widths, the controller state encoding and a row-slice
// helper. Row 0 of a matrix always sits in the most-significant bits.
package data_xf_pkg;

  localparam int W     = 8;
  localparam int ROW_W = 4 * W;
  localparam int MAT_W = 16 * W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } xf_state_e;

  // Row idx of a matrix; row 0 is the top ROW_W bits.
  function automatic logic [ROW_W-1:0] get_row(input logic [MAT_W-1:0] mat,
                                                input logic [1:0]       idx);
    return mat[MAT_W-1-int'(idx)*ROW_W -: ROW_W];
  endfunction

endpackage

// File: rtl/data_4x4_transform_ctrl.sv
// Sequencer for the 4x4 byte-matrix transform: gathers 4 input rows into a
// matrix, holds it on xf_data for XF_LATENCY cycles, captures xf_result and
// drains it as 4 output rows. First out_valid comes 1+XF_LATENCY cycles after
// the 4th row is accepted. in_ready is low from the 4th accept until the last
// output handshake; out_valid/out_row hold steady while out_ready is low.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input row handshake, in_row = 4*W bit row
//   xf_data, xf_start   registered matrix to the transform, 1-cycle start pulse
//   xf_result           transform output, sampled at the end of WAIT
//   out_valid/out_ready output row handshake, out_row = 4*W bit row
//   busy                high unless idle in LOAD with no rows collected
//   blk_cnt             count of fully drained matrices (wraps)
module data_4x4_transform_ctrl #(
  parameter int W          = 8,
  parameter int XF_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*W-1:0]     in_row,
  output logic [16*W-1:0]    xf_data,
  output logic               xf_start,
  input  logic [16*W-1:0]    xf_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*W-1:0]     out_row,
  output logic               busy,
  output logic [CNT_W-1:0]   blk_cnt
);

  import data_xf_pkg::*;

  // get_row() is sized by the package widths; W is expected to match them.
  localparam int RW = 4 * W;
  localparam int MW = 16 * W;

  // Wait counter only needs to reach XF_LATENCY-1.
  localparam int                WCNT_W    = (XF_LATENCY > 1) ? $clog2(XF_LATENCY) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(XF_LATENCY - 1);

  xf_state_e         r_state;
  xf_state_e         w_state_nxt;
  logic [1:0]        r_rcnt;
  logic [1:0]        w_rcnt_nxt;
  logic [WCNT_W-1:0] r_wcnt;
  logic [WCNT_W-1:0] w_wcnt_nxt;
  logic [MW-1:0]     r_mat;
  logic [MW-1:0]     w_mat_nxt;
  logic [MW-1:0]     r_buf;
  logic [MW-1:0]     w_buf_nxt;
  logic              r_xf_start;
  logic              w_start_nxt;
  logic [CNT_W-1:0]  r_blk_cnt;
  logic [CNT_W-1:0]  w_blk_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [RW-1:0]     r_out_row;

  logic              w_in_fire;
  logic              w_out_fire;

  assign w_in_fire  = in_valid && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_wcnt_nxt  = r_wcnt;
    w_mat_nxt   = r_mat;
    w_buf_nxt   = r_buf;
    w_start_nxt = 1'b0;
    w_blk_nxt   = r_blk_cnt;

    unique case (r_state)
      LOAD: begin
        if (w_in_fire) begin
          // Overwrite one row slot; untouched slots keep the previous matrix.
          for (int i = 0; i < 4; i++) begin
            if (r_rcnt == 2'(i)) begin
              w_mat_nxt[MW-1-i*RW -: RW] = in_row;
            end
          end
          if (r_rcnt == 2'd3) begin
            w_rcnt_nxt  = 2'd0;
            w_wcnt_nxt  = '0;
            w_start_nxt = 1'b1;
            w_state_nxt = WAIT;
          end else begin
            w_rcnt_nxt = r_rcnt + 2'd1;
          end
        end
      end

      WAIT: begin
        w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        if (r_wcnt == WCNT_LAST) begin
          w_buf_nxt   = xf_result;
          w_state_nxt = DRAIN;
        end
      end

      DRAIN: begin
        if (w_out_fire) begin
          if (r_rcnt == 2'd3) begin
            w_rcnt_nxt  = 2'd0;
            w_blk_nxt   = r_blk_cnt + CNT_W'(1);
            w_state_nxt = LOAD;
          end else begin
            w_rcnt_nxt = r_rcnt + 2'd1;
          end
        end
      end

      default: begin
        w_state_nxt = LOAD;
        w_rcnt_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= LOAD;
      r_rcnt      <= 2'd0;
      r_wcnt      <= '0;
      r_mat       <= '0;
      r_buf       <= '0;
      r_xf_start  <= 1'b0;
      r_blk_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_wcnt      <= w_wcnt_nxt;
      r_mat       <= w_mat_nxt;
      r_buf       <= w_buf_nxt;
      r_xf_start  <= w_start_nxt;
      r_blk_cnt   <= w_blk_nxt;
      // Handshake flags are registered from the next state so they are clean
      // flop outputs and stay low through the reset cycle.
      r_in_ready  <= (w_state_nxt == LOAD);
      r_out_valid <= (w_state_nxt == DRAIN);
      // Row index and buffer are frozen under backpressure, so out_row holds.
      if (w_state_nxt == DRAIN) begin
        r_out_row <= get_row(w_buf_nxt, w_rcnt_nxt);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign xf_data   = r_mat;
  assign xf_start  = r_xf_start;
  assign blk_cnt   = r_blk_cnt;
  assign busy      = !((r_state == LOAD) && (r_rcnt == 2'd0));

endmodule

// File: tb/tb_data_4x4_transform_ctrl.sv
// Bench for data_4x4_transform_ctrl: instance A (XF_LATENCY=1, CNT_W=16) and
// instance B (XF_LATENCY=3, CNT_W=2), each fed by a transpose model of the
// transform with the matching latency. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_data_4x4_transform_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Instance A signals
  logic         a_rst, a_in_valid, a_in_ready, a_xf_start, a_out_valid, a_out_ready, a_busy;
  logic [31:0]  a_in_row, a_out_row;
  logic [127:0] a_xf_data, a_xf_result;
  logic [15:0]  a_blk_cnt;

  // Instance B signals
  logic         b_rst, b_in_valid, b_in_ready, b_xf_start, b_out_valid, b_out_ready, b_busy;
  logic [31:0]  b_in_row, b_out_row;
  logic [127:0] b_xf_data, b_xf_result;
  logic [1:0]   b_blk_cnt;

  data_4x4_transform_ctrl #(.W(8), .XF_LATENCY(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row),
    .xf_data(a_xf_data), .xf_start(a_xf_start), .xf_result(a_xf_result),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_row(a_out_row),
    .busy(a_busy), .blk_cnt(a_blk_cnt)
  );

  data_4x4_transform_ctrl #(.W(8), .XF_LATENCY(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
    .xf_data(b_xf_data), .xf_start(b_xf_start), .xf_result(b_xf_result),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
    .busy(b_busy), .blk_cnt(b_blk_cnt)
  );

  // Transform model: byte transpose. Latency 1 = combinational; latency 3 =
  // two register stages so the result is valid in the last WAIT cycle.
  function automatic logic [127:0] transpose(input logic [127:0] m);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[127-(r*4+c)*8 -: 8] = m[127-(c*4+r)*8 -: 8];
    return t;
  endfunction

  logic [127:0] b_d1, b_d2;
  assign a_xf_result = transpose(a_xf_data);
  always @(posedge clk) begin
    b_d1 <= transpose(b_xf_data);
    b_d2 <= b_d1;
  end
  assign b_xf_result = b_d2;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic rdy(input bit b);  return b ? b_in_ready : a_in_ready;   endfunction
  function automatic logic ovld(input bit b); return b ? b_out_valid : a_out_valid; endfunction
  function automatic logic xfs(input bit b);  return b ? b_xf_start : a_xf_start;   endfunction
  function automatic logic bsy(input bit b);  return b ? b_busy : a_busy;           endfunction
  function automatic logic [31:0]  orow(input bit b) ; return b ? b_out_row : a_out_row; endfunction
  function automatic logic [127:0] xfd(input bit b);   return b ? b_xf_data : a_xf_data; endfunction
  function automatic logic [15:0]  blk(input bit b);   return b ? 16'(b_blk_cnt) : a_blk_cnt; endfunction
  function automatic logic [31:0]  row_of(input logic [127:0] m, input int i);
    return m[127-i*32 -: 32];
  endfunction

  task automatic set_in(input bit b, input logic v, input logic [31:0] row);
    if (b) begin b_in_valid = v; b_in_row = row; end
    else   begin a_in_valid = v; a_in_row = row; end
  endtask
  task automatic set_ordy(input bit b, input logic v);
    if (b) b_out_ready = v; else a_out_ready = v;
  endtask
  task automatic set_rst(input bit b, input logic v);
    if (b) b_rst = v; else a_rst = v;
  endtask

  // All tasks below are entered and left on a falling edge.
  task automatic do_reset(input bit b, input int n, input string tag);
    set_rst(b, 1'b1);
    repeat (n) @(negedge clk);
    check_eq({tag, "_in_ready"},  rdy(b),  1'b0);
    check_eq({tag, "_out_valid"}, ovld(b), 1'b0);
    check_eq({tag, "_xf_data"},   xfd(b),  128'h0);
    check_eq({tag, "_xf_start"},  xfs(b),  1'b0);
    check_eq({tag, "_out_row"},   orow(b), 32'h0);
    check_eq({tag, "_blk_cnt"},   blk(b),  16'h0);
    check_eq({tag, "_busy"},      bsy(b),  1'b0);
    set_rst(b, 1'b0);
    @(negedge clk);
    check_eq({tag, "_in_ready_rel"}, rdy(b), 1'b1);
  endtask

  task automatic send_mat(input bit b, input logic [127:0] m, input bit bubbles,
                          input string tag, output int t4);
    int  i = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    logic v;
    t4 = -1;
    while (i < 4 && guard < 200) begin
      v  = bubbles ? ph : 1'b1;
      ph = !ph;
      set_in(b, v, v ? row_of(m, i) : 32'hDEADBEEF);
      if (v && rdy(b)) begin
        if (i == 3) t4 = cyc;
        i++;
      end
      @(negedge clk);
      guard++;
    end
    set_in(b, 1'b0, 32'hDEADBEEF);
    check_eq({tag, "_rows_taken"}, i, 4);
    check_eq({tag, "_xf_data"},  xfd(b),  m);
    check_eq({tag, "_xf_start"}, xfs(b),  1'b1);
    check_eq({tag, "_wait_rdy"}, rdy(b),  1'b0);
    check_eq({tag, "_wait_vld"}, ovld(b), 1'b0);
    check_eq({tag, "_busy"},     bsy(b),  1'b1);
    @(negedge clk);
    check_eq({tag, "_start_1c"}, xfs(b), 1'b0);
  endtask

  task automatic wait_vld(input bit b, input int t4, input int lat, input string tag);
    int guard = 0;
    while (!ovld(b) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_first_vld_lat"}, 128'(cyc - t4), 128'(1 + lat));
  endtask

  task automatic take_row(input bit b, input logic [31:0] exp, input string tag);
    check_eq({tag, "_vld"}, ovld(b), 1'b1);
    check_eq({tag, "_row"}, orow(b), exp);
    @(negedge clk);
  endtask

  task automatic recv_mat(input bit b, input logic [127:0] exp, input int t4, input int lat,
                          input int stall_row, input int stall_n, input string tag);
    wait_vld(b, t4, lat, tag);
    for (int r = 0; r < 4; r++) begin
      if (r == stall_row) begin
        set_ordy(b, 1'b0);
        for (int k = 0; k < stall_n; k++) begin
          check_eq($sformatf("%s_hold%0d_vld", tag, k), ovld(b), 1'b1);
          check_eq($sformatf("%s_hold%0d_row", tag, k), orow(b), row_of(exp, r));
          check_eq($sformatf("%s_hold%0d_rdy", tag, k), rdy(b),  1'b0);
          @(negedge clk);
        end
        set_ordy(b, 1'b1);
      end
      take_row(b, row_of(exp, r), $sformatf("%s_r%0d", tag, r));
    end
    check_eq({tag, "_done_vld"}, ovld(b), 1'b0);
    check_eq({tag, "_done_rdy"}, rdy(b),  1'b1);
  endtask

  localparam logic [127:0] M2  = 128'h01010101_02020202_03030303_04040404;
  localparam logic [127:0] X2  = 128'h01020304_01020304_01020304_01020304;
  localparam logic [127:0] M5  = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] X5  = 128'h0004080C_0105090D_02060A0E_03070B0F;
  localparam logic [127:0] M6  = 128'h11121314_21222324_31323334_41424344;
  localparam logic [127:0] X6  = 128'h11213141_12223242_13233343_14243444;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t4;
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_row = '0; a_out_ready = 1'b1;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_row = '0; b_out_ready = 1'b1;
    @(negedge clk);

    // Reset sequence
    do_reset(0, 4, "t1");

    // Single matrix, consumer always ready
    send_mat(0, M2, 1'b0, "t2", t4);
    recv_mat(0, X2, t4, 1, -1, 0, "t2");
    check_eq("t2_blk_cnt", blk(0), 16'd1);

    // Input bubbles
    send_mat(0, M2, 1'b1, "t3", t4);
    recv_mat(0, X2, t4, 1, -1, 0, "t3");
    check_eq("t3_blk_cnt", blk(0), 16'd2);

    // Output backpressure on row 1
    send_mat(0, M2, 1'b0, "t4", t4);
    recv_mat(0, X2, t4, 1, 1, 5, "t4");
    check_eq("t4_blk_cnt", blk(0), 16'd3);

    // Reset mid-DRAIN (instance B), then a fresh matrix
    do_reset(1, 4, "t5a");
    send_mat(1, M6, 1'b0, "t5b", t4);
    wait_vld(1, t4, 3, "t5b");
    take_row(1, row_of(X6, 0), "t5b_r0");
    take_row(1, row_of(X6, 1), "t5b_r1");
    do_reset(1, 1, "t5c");
    send_mat(1, M5, 1'b0, "t5d", t4);
    recv_mat(1, X5, t4, 3, -1, 0, "t5d");
    check_eq("t5_blk_cnt", blk(1), 16'd1);

    // Back-to-back with XF_LATENCY=3, then wrap of a 2-bit counter
    do_reset(1, 2, "t6");
    send_mat(1, M6, 1'b0, "t6m0", t4);
    recv_mat(1, X6, t4, 3, -1, 0, "t6m0");
    send_mat(1, M5, 1'b0, "t6m1", t4);
    recv_mat(1, X5, t4, 3, -1, 0, "t6m1");
    send_mat(1, M2, 1'b0, "t6m2", t4);
    recv_mat(1, X2, t4, 3, -1, 0, "t6m2");
    check_eq("t6_blk_cnt3", blk(1), 16'd3);
    send_mat(1, M6, 1'b0, "t6m3", t4);
    recv_mat(1, X6, t4, 3, -1, 0, "t6m3");
    check_eq("t6_blk_wrap", blk(1), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
